// File: rtl/hdmi_mode_sequencer.sv
// Sequences NTSC/PAL mode changes for the HDMI output stage: qualify the request,
// wait for a frame boundary, mute audio, reset the stage across the switch, then unmute.
module hdmi_mode_sequencer #(
  parameter logic        PAL_DEFAULT    = 1'b0,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MUTE_CYCLES    = 256,
  parameter int unsigned RESET_CYCLES   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        pal_mode_req,
  input  logic        include_audio_req,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  output logic        pal_mode,
  output logic        hdmi_reset,
  output logic        include_audio,
  output logic        switching,
  output logic [7:0]  switch_count
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_QUALIFY    = 3'd2,
    S_WAIT_FRAME = 3'd3,
    S_MUTE       = 3'd4,
    S_RESET      = 3'd5,
    S_RECOVER    = 3'd6
  } state_t;

  localparam logic [19:0] STABLE_LAST  = 20'(STABLE_CYCLES - 1);
  localparam logic [19:0] MUTE_LAST    = 20'(MUTE_CYCLES - 1);
  localparam logic [19:0] RESET_LAST   = 20'(RESET_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        req_meta_q, req_s_q;
  logic        pal_q, pal_d;
  logic        hdmi_reset_q, hdmi_reset_d;
  logic        audio_q, audio_d;
  logic        switching_q, switching_d;
  logic        from_reset_q, from_reset_d;
  logic [7:0]  count_q, count_d;
  logic        frame_start_s;
  logic        mismatch_s;

  // The HDMI stage's counters are meaningless while it is held in reset.
  assign frame_start_s = (cx == 11'd0) && (cy == 10'd0) && !hdmi_reset_q;
  assign mismatch_s    = (req_s_q != pal_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 20'd1;
    pal_d        = pal_q;
    from_reset_d = from_reset_q;
    count_d      = count_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == RESET_LAST) state_d = S_RECOVER;
        else                     state_d = S_INIT;
      end
      S_IDLE: begin
        if (mismatch_s) state_d = S_QUALIFY;
        else            state_d = S_IDLE;
      end
      S_QUALIFY: begin
        if (!mismatch_s)               state_d = S_IDLE;
        else if (cnt_q == STABLE_LAST) state_d = S_WAIT_FRAME;
        else                           state_d = S_QUALIFY;
      end
      S_WAIT_FRAME: begin
        if (!mismatch_s)                                  state_d = S_IDLE;
        else if (frame_start_s || cnt_q == TIMEOUT_LAST) state_d = S_MUTE;
        else                                              state_d = S_WAIT_FRAME;
      end
      S_MUTE: begin
        if (cnt_q == MUTE_LAST) state_d = S_RESET;
        else                    state_d = S_MUTE;
      end
      S_RESET: begin
        if (cnt_q == RESET_LAST) state_d = S_RECOVER;
        else                     state_d = S_RESET;
      end
      S_RECOVER: begin
        if (frame_start_s || cnt_q == TIMEOUT_LAST) state_d = S_IDLE;
        else                                         state_d = S_RECOVER;
      end
      default: state_d = S_INIT;
    endcase

    if (state_d != state_q || state_q == S_IDLE) cnt_d = 20'd0;
    else                                         cnt_d = cnt_q + 20'd1;

    // Mode flips on the same edge that raises hdmi_reset.
    if (state_q == S_MUTE && state_d == S_RESET) pal_d = ~pal_q;
    else                                         pal_d = pal_q;

    if (state_d == S_RECOVER && state_q != S_RECOVER) from_reset_d = (state_q == S_RESET);
    else                                              from_reset_d = from_reset_q;

    if (state_q == S_RECOVER && state_d == S_IDLE && from_reset_q) count_d = count_q + 8'd1;
    else                                                           count_d = count_q;

    hdmi_reset_d = (state_d == S_INIT) || (state_d == S_RESET);
    switching_d  = (state_d != S_IDLE);
    if (state_d == S_IDLE || state_d == S_QUALIFY || state_d == S_WAIT_FRAME)
      audio_d = include_audio_req;
    else
      audio_d = 1'b0;
  end

  // Request synchroniser, state, counter and registered outputs.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q   <= PAL_DEFAULT;
      req_s_q      <= PAL_DEFAULT;
      state_q      <= S_INIT;
      cnt_q        <= 20'd0;
      pal_q        <= PAL_DEFAULT;
      hdmi_reset_q <= 1'b1;
      audio_q      <= 1'b0;
      switching_q  <= 1'b1;
      from_reset_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      req_meta_q   <= pal_mode_req;
      req_s_q      <= req_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pal_q        <= pal_d;
      hdmi_reset_q <= hdmi_reset_d;
      audio_q      <= audio_d;
      switching_q  <= switching_d;
      from_reset_q <= from_reset_d;
      count_q      <= count_d;
    end
  end

  assign pal_mode      = pal_q;
  assign hdmi_reset    = hdmi_reset_q;
  assign include_audio = audio_q;
  assign switching     = switching_q;
  assign switch_count  = count_q;

endmodule

// File: doc/hdmi_mode_sequencer.md
# hdmi_mode_sequencer

Sequences safe NTSC/PAL video-mode changes for the HDMI output stage, which renders both timing variants in parallel and selects one through `pal_mode`. The block qualifies a mode request, waits for a frame boundary, mutes audio, holds the HDMI stage in reset across the switch, and unmutes on the first clean frame of the new mode. It runs in the pixel clock domain, between the VDP register file (mode request source) and the HDMI selection stage (consumer of `pal_mode`, `reset` and `include_audio`).

## Interface
- `PAL_DEFAULT`, 0: mode driven on `pal_mode` out of reset.
- `STABLE_CYCLES`, 1024: consecutive cycles the synchronised request must differ from `pal_mode` before the switch is accepted.
- `MUTE_CYCLES`, 256: audio-muted cycles before reset is asserted.
- `RESET_CYCLES`, 64: cycles `hdmi_reset` is held high.
- `TIMEOUT_CYCLES`, 1048576: maximum wait for a frame start in WAIT_FRAME and RECOVER.
- `clk_pixel  in  1`: pixel clock; all state is on its rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `pal_mode_req  in  1`: requested mode (1 = PAL); asynchronous to `clk_pixel`.
- `include_audio_req  in  1`: audio enable from the register file.
- `cx  in  11`: current horizontal position from the HDMI stage.
- `cy  in  10`: current vertical position from the HDMI stage.
- `pal_mode  out  1`: selected mode to the HDMI stage.
- `hdmi_reset  out  1`: active-high reset to the HDMI stage.
- `include_audio  out  1`: gated audio enable to the HDMI stage.
- `switching  out  1`: high in any state except IDLE.
- `switch_count  out  8`: completed switches; wraps 255 -> 0.

## Operation
- `pal_mode_req` passes through a 2-flop synchroniser, producing `req_s`.
- `frame_start` = (`cx` == 0 && `cy` == 0). It is ignored while `hdmi_reset` is high.
- A single 20-bit counter `cnt` is cleared on every state entry.
- State machine:
  - INIT: entered from reset. `hdmi_reset`=1 for RESET_CYCLES, then go to RECOVER.
  - IDLE: if `req_s` != `pal_mode`, go to QUALIFY.
  - QUALIFY: count while `req_s` != `pal_mode`. If `req_s` == `pal_mode`, go back to IDLE. When `cnt` reaches STABLE_CYCLES-1, go to WAIT_FRAME.
  - WAIT_FRAME: if `req_s` == `pal_mode`, abort to IDLE. On `frame_start`, or when `cnt` reaches TIMEOUT_CYCLES-1, go to MUTE.
  - MUTE: `include_audio`=0. After MUTE_CYCLES, go to RESET. From MUTE onward the switch is committed.
  - RESET: on entry `pal_mode` <= !`pal_mode` and `hdmi_reset`=1. After RESET_CYCLES, go to RECOVER.
  - RECOVER: `hdmi_reset`=0, `include_audio`=0. On `frame_start`, or on timeout, go to IDLE. If arrived from RESET, `switch_count` increments on this exit.
- `include_audio` = `include_audio_req` only in IDLE, QUALIFY and WAIT_FRAME; it is 0 in every other state.
- A request change during MUTE, RESET or RECOVER is not lost: IDLE re-evaluates `req_s` on its first cycle.
- A request that toggles twice within the synchroniser or QUALIFY window produces no switch.

## Timing
- Reset values while `reset_n`=0: `pal_mode`=PAL_DEFAULT, `hdmi_reset`=1, `include_audio`=0, `switching`=1, `switch_count`=0, state=INIT.
- All outputs are registered. A state transition decided in cycle t is visible on outputs at t+1.
- Minimum switch latency: 2 (synchroniser) + STABLE_CYCLES + 1 (WAIT_FRAME if `frame_start` is already true) + MUTE_CYCLES + RESET_CYCLES + RECOVER duration.
- `pal_mode` and the rising edge of `hdmi_reset` change in the same cycle, so the HDMI stage never runs unreset on a mode glitch.
- `hdmi_reset` falls exactly RESET_CYCLES cycles after it rises.
- `reset_n` asserted mid-switch aborts immediately to the reset values. `pal_mode` returns to PAL_DEFAULT regardless of any switch in progress.

## Test plan
- Reset release, with STABLE=8, MUTE=4, RESET=3, PAL_DEFAULT=0 -> `hdmi_reset` high for exactly 3 cycles after release. `include_audio` stays 0 until the first `cx`=0/`cy`=0, then follows `include_audio_req`=1. `switch_count`=0.
- `pal_mode_req` 0->1 held, `frame_start` pulsed 20 cycles later -> MUTE begins the cycle after the pulse. `include_audio` is 0 for 4 cycles, then `pal_mode`=1 and `hdmi_reset`=1 for 3 cycles. After the next frame start, `switch_count`=1.
- `pal_mode_req` high for 5 cycles, then low -> no MUTE, `pal_mode`=0, `include_audio` never drops.
- Request withdrawn while in WAIT_FRAME -> return to IDLE, audio uninterrupted, `switch_count` unchanged.
- `cx`/`cy` never reach 0, with TIMEOUT=16 -> WAIT_FRAME exits after 16 cycles. The switch completes, and RECOVER exits on its own 16-cycle timeout.
- `reset_n` pulsed low during RESET with `pal_mode`=1 -> outputs return to `pal_mode`=0 and `hdmi_reset`=1 immediately (asynchronous), then the INIT sequence repeats. A still-high request is then re-qualified.
